// File: rtl/e203_exu_wbck_rob_if.sv
// Handshake bundle of the long-pipe write-back reorder unit: producer channels,
// OITF head view/retire strobe and the registered write-back port.
interface e203_exu_wbck_rob_if #(
  parameter int CH_NUM  = 2,
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int ITAG_W  = 2
);
  logic [CH_NUM-1:0]         ch_i_valid;
  logic [CH_NUM-1:0]         ch_i_ready;
  logic [CH_NUM*XLEN-1:0]    ch_i_wdat;
  logic [CH_NUM*RFIDX_W-1:0] ch_i_rdidx;
  logic [CH_NUM-1:0]         ch_i_rdwen;
  logic [CH_NUM*ITAG_W-1:0]  ch_i_itag;
  logic                      oitf_empty;
  logic [ITAG_W-1:0]         oitf_ret_ptr;
  logic                      oitf_ret_ena;
  logic                      wbck_o_valid;
  logic                      wbck_o_ready;
  logic [XLEN-1:0]           wbck_o_wdat;
  logic [RFIDX_W-1:0]        wbck_o_rdidx;
  logic                      err_dup_match;

  modport master (
    output ch_i_valid, ch_i_wdat, ch_i_rdidx, ch_i_rdwen, ch_i_itag,
    output oitf_empty, oitf_ret_ptr, wbck_o_ready,
    input  ch_i_ready, oitf_ret_ena, wbck_o_valid, wbck_o_wdat, wbck_o_rdidx,
    input  err_dup_match
  );

  modport slave (
    input  ch_i_valid, ch_i_wdat, ch_i_rdidx, ch_i_rdwen, ch_i_itag,
    input  oitf_empty, oitf_ret_ptr, wbck_o_ready,
    output ch_i_ready, oitf_ret_ena, wbck_o_valid, wbck_o_wdat, wbck_o_rdidx,
    output err_dup_match
  );
endinterface

// File: rtl/e203_exu_wbck_rob.sv
// Multi-channel write-back reorder unit: per-channel result FIFOs drained strictly
// in OITF order into one registered write-back port.
module e203_exu_wbck_rob #(
  parameter int CH_NUM     = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int ITAG_W     = 2
) (
  input logic                clk,
  input logic                rst,
  e203_exu_wbck_rob_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [CH_NUM-1:0]         head_vld;
  logic [CH_NUM-1:0]         head_rdwen;
  logic [CH_NUM*XLEN-1:0]    head_wdat;
  logic [CH_NUM*RFIDX_W-1:0] head_rdidx;
  logic [CH_NUM*ITAG_W-1:0]  head_itag;
  logic [CH_NUM-1:0]         ready_vec;
  logic [CH_NUM-1:0]         pop_vec;
  logic [CH_NUM-1:0]         match;
  logic [CH_NUM-1:0]         sel_oh;
  logic                      dup;
  logic                      sel_rdwen;
  logic [XLEN-1:0]           sel_wdat;
  logic [RFIDX_W-1:0]        sel_rdidx;
  logic                      slot_free;
  logic                      pop_ok;
  logic                      load;

  logic                      wbck_valid_q, wbck_valid_d;
  logic [XLEN-1:0]           wbck_wdat_q, wbck_wdat_d;
  logic [RFIDX_W-1:0]        wbck_rdidx_q, wbck_rdidx_d;
  logic                      err_dup_q, err_dup_d;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
      logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
      logic [XLEN-1:0]    wdat_mem_q  [FIFO_DEPTH];
      logic [RFIDX_W-1:0] rdidx_mem_q [FIFO_DEPTH];
      logic               rdwen_mem_q [FIFO_DEPTH];
      logic [ITAG_W-1:0]  itag_mem_q  [FIFO_DEPTH];
      logic               full;
      logic               empty;
      logic               push;

      assign empty = (wr_ptr_q == rd_ptr_q);
      assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      // Ready looks only at fullness so a same-cycle pop never feeds back into it.
      assign ready_vec[gi] = ~full & ~rst;
      assign push          = bus.ch_i_valid[gi] & ready_vec[gi];

      always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop_vec[gi]);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
        end
      end

      always_ff @(posedge clk) begin
        if (push) begin
          wdat_mem_q[wr_ptr_q[AW-1:0]]  <= bus.ch_i_wdat[gi*XLEN +: XLEN];
          rdidx_mem_q[wr_ptr_q[AW-1:0]] <= bus.ch_i_rdidx[gi*RFIDX_W +: RFIDX_W];
          rdwen_mem_q[wr_ptr_q[AW-1:0]] <= bus.ch_i_rdwen[gi];
          itag_mem_q[wr_ptr_q[AW-1:0]]  <= bus.ch_i_itag[gi*ITAG_W +: ITAG_W];
        end
      end

      assign head_vld[gi]                         = ~empty;
      assign head_wdat[gi*XLEN +: XLEN]           = wdat_mem_q[rd_ptr_q[AW-1:0]];
      assign head_rdidx[gi*RFIDX_W +: RFIDX_W]    = rdidx_mem_q[rd_ptr_q[AW-1:0]];
      assign head_rdwen[gi]                       = rdwen_mem_q[rd_ptr_q[AW-1:0]];
      assign head_itag[gi*ITAG_W +: ITAG_W]       = itag_mem_q[rd_ptr_q[AW-1:0]];
    end
  endgenerate

  always_comb begin
    match = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      match[k] = head_vld[k] & (head_itag[k*ITAG_W +: ITAG_W] == bus.oitf_ret_ptr) &
                 ~bus.oitf_empty & ~rst;
    end
    // Isolate the lowest set bit; any other bit left over means a duplicate itag.
    sel_oh = match & (~match + CH_NUM'(1));
    dup    = |(match & (match - CH_NUM'(1)));

    sel_wdat  = '0;
    sel_rdidx = '0;
    sel_rdwen = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (sel_oh[k]) begin
        sel_wdat  = head_wdat[k*XLEN +: XLEN];
        sel_rdidx = head_rdidx[k*RFIDX_W +: RFIDX_W];
        sel_rdwen = head_rdwen[k];
      end
    end

    slot_free = ~wbck_valid_q | bus.wbck_o_ready;
    // Results without a destination retire even when the output slot is stalled.
    pop_ok    = (|match) & (~sel_rdwen | slot_free);
    load      = pop_ok & sel_rdwen;
    pop_vec   = pop_ok ? sel_oh : '0;

    wbck_valid_d = load | (wbck_valid_q & ~bus.wbck_o_ready);
    wbck_wdat_d  = load ? sel_wdat  : wbck_wdat_q;
    wbck_rdidx_d = load ? sel_rdidx : wbck_rdidx_q;
    err_dup_d    = err_dup_q | dup;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbck_valid_q <= 1'b0;
      wbck_wdat_q  <= '0;
      wbck_rdidx_q <= '0;
      err_dup_q    <= 1'b0;
    end else begin
      wbck_valid_q <= wbck_valid_d;
      wbck_wdat_q  <= wbck_wdat_d;
      wbck_rdidx_q <= wbck_rdidx_d;
      err_dup_q    <= err_dup_d;
    end
  end

  assign bus.ch_i_ready    = ready_vec;
  assign bus.oitf_ret_ena  = pop_ok;
  assign bus.wbck_o_valid  = wbck_valid_q;
  assign bus.wbck_o_wdat   = wbck_wdat_q;
  assign bus.wbck_o_rdidx  = wbck_rdidx_q;
  assign bus.err_dup_match = err_dup_q;
endmodule

// File: tb/tb_e203_exu_wbck_rob.sv
// Bench for the write-back reorder unit: directed scenarios plus a randomized
// run checked against an in-order instruction list and per-channel queues.
module tb_e203_exu_wbck_rob;
  localparam int CH = 2;
  localparam int DEPTH = 2;
  localparam int XL = 32;
  localparam int RW = 5;
  localparam int IW = 2;
  localparam int N = 48;

  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  e203_exu_wbck_rob_if #(.CH_NUM(CH), .XLEN(XL), .RFIDX_W(RW), .ITAG_W(IW)) bus ();

  e203_exu_wbck_rob #(.CH_NUM(CH), .FIFO_DEPTH(DEPTH), .XLEN(XL), .RFIDX_W(RW), .ITAG_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_ch(input int k, input logic v, input logic [XL-1:0] d,
                        input logic [RW-1:0] r, input logic we, input logic [IW-1:0] it);
    bus.ch_i_valid[k]          = v;
    bus.ch_i_wdat[k*XL +: XL]  = d;
    bus.ch_i_rdidx[k*RW +: RW] = r;
    bus.ch_i_rdwen[k]          = we;
    bus.ch_i_itag[k*IW +: IW]  = it;
  endtask

  task automatic idle();
    bus.ch_i_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.ch_i_wdat = '0; bus.ch_i_rdidx = '0; bus.ch_i_rdwen = '0; bus.ch_i_itag = '0;
    bus.oitf_empty = 1'b0; bus.oitf_ret_ptr = '0; bus.wbck_o_ready = 1'b1;
    tick(); tick(); settle();
    checks++; if (bus.ch_i_ready !== 2'b00) begin errors++; $display("FAIL reset_ready_in_rst: got %b expected 00", bus.ch_i_ready); end
    checks++; if (bus.oitf_ret_ena !== 1'b0) begin errors++; $display("FAIL reset_ret_ena_in_rst: got %b expected 0", bus.oitf_ret_ena); end
    rst = 1'b0;
    #1;
    checks++; if (bus.ch_i_ready !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b expected 11", bus.ch_i_ready); end
    checks++; if (bus.wbck_o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.wbck_o_valid); end
    checks++; if (bus.wbck_o_wdat !== 32'h0 || bus.wbck_o_rdidx !== 5'd0) begin errors++; $display("FAIL reset_data: got %h/%0d expected 0/0", bus.wbck_o_wdat, bus.wbck_o_rdidx); end
    checks++; if (bus.err_dup_match !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err_dup_match); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    bus.oitf_ret_ptr = 2'd0; bus.wbck_o_ready = 1'b1;
    set_ch(0, 1'b1, 32'hDEADBEEF, 5'd5, 1'b1, 2'd0);
    settle();
    checks++; if (bus.ch_i_ready[0] !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", bus.ch_i_ready[0]); end
    tick(); idle(); settle();
    checks++; if (bus.oitf_ret_ena !== 1'b1) begin errors++; $display("FAIL single_ret_ena_t1: got %b expected 1", bus.oitf_ret_ena); end
    checks++; if (bus.wbck_o_valid !== 1'b0) begin errors++; $display("FAIL single_valid_t1: got %b expected 0", bus.wbck_o_valid); end
    tick(); settle();
    checks++; if (bus.wbck_o_valid !== 1'b1) begin errors++; $display("FAIL single_valid_t2: got %b expected 1", bus.wbck_o_valid); end
    checks++; if (bus.wbck_o_wdat !== 32'hDEADBEEF || bus.wbck_o_rdidx !== 5'd5) begin errors++; $display("FAIL single_data: got %h/%0d expected deadbeef/5", bus.wbck_o_wdat, bus.wbck_o_rdidx); end
    checks++; if (bus.oitf_ret_ena !== 1'b0) begin errors++; $display("FAIL single_ret_ena_t2: got %b expected 0", bus.oitf_ret_ena); end
    bus.oitf_ret_ptr = 2'd1;
    tick(); settle();
    checks++; if (bus.wbck_o_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", bus.wbck_o_valid); end
    $display("test_single done");
  endtask

  task automatic test_out_of_order();
    bus.oitf_ret_ptr = 2'd0; bus.wbck_o_ready = 1'b1;
    set_ch(1, 1'b1, 32'hA1A1A1A1, 5'd11, 1'b1, 2'd1);
    tick(); idle(); settle();
    checks++; if (bus.oitf_ret_ena !== 1'b0) begin errors++; $display("FAIL ooo_hold1: got %b expected 0", bus.oitf_ret_ena); end
    tick();
    set_ch(0, 1'b1, 32'hA0A0A0A0, 5'd10, 1'b1, 2'd0);
    settle();
    checks++; if (bus.oitf_ret_ena !== 1'b0 || bus.wbck_o_valid !== 1'b0) begin errors++; $display("FAIL ooo_hold2: got ret=%b valid=%b expected 0/0", bus.oitf_ret_ena, bus.wbck_o_valid); end
    tick(); idle(); settle();
    checks++; if (bus.oitf_ret_ena !== 1'b1) begin errors++; $display("FAIL ooo_ret0: got %b expected 1", bus.oitf_ret_ena); end
    tick(); bus.oitf_ret_ptr = 2'd1; settle();
    checks++; if (bus.oitf_ret_ena !== 1'b1) begin errors++; $display("FAIL ooo_ret1: got %b expected 1", bus.oitf_ret_ena); end
    checks++; if (bus.wbck_o_valid !== 1'b1 || bus.wbck_o_wdat !== 32'hA0A0A0A0) begin errors++; $display("FAIL ooo_wb0: got %b/%h expected 1/a0a0a0a0", bus.wbck_o_valid, bus.wbck_o_wdat); end
    tick(); bus.oitf_ret_ptr = 2'd2; settle();
    checks++; if (bus.wbck_o_valid !== 1'b1 || bus.wbck_o_wdat !== 32'hA1A1A1A1 || bus.wbck_o_rdidx !== 5'd11) begin errors++; $display("FAIL ooo_wb1: got %b/%h/%0d expected 1/a1a1a1a1/11", bus.wbck_o_valid, bus.wbck_o_wdat, bus.wbck_o_rdidx); end
    checks++; if (bus.oitf_ret_ena !== 1'b0) begin errors++; $display("FAIL ooo_no_more: got %b expected 0", bus.oitf_ret_ena); end
    tick();
    $display("test_out_of_order done");
  endtask

  task automatic test_backpressure();
    bus.oitf_ret_ptr = 2'd0; bus.wbck_o_ready = 1'b0;
    set_ch(0, 1'b1, 32'hB0B0B0B0, 5'd1, 1'b1, 2'd0);
    set_ch(1, 1'b1, 32'hB1B1B1B1, 5'd2, 1'b1, 2'd1);
    tick(); idle(); settle();
    checks++; if (bus.oitf_ret_ena !== 1'b1) begin errors++; $display("FAIL bp_first_ret: got %b expected 1", bus.oitf_ret_ena); end
    tick(); bus.oitf_ret_ptr = 2'd1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      settle();
      checks++; if (bus.wbck_o_valid !== 1'b1 || bus.wbck_o_wdat !== 32'hB0B0B0B0) begin errors++; $display("FAIL bp_stable[%0d]: got %b/%h expected 1/b0b0b0b0", i, bus.wbck_o_valid, bus.wbck_o_wdat); end
      checks++; if (bus.oitf_ret_ena !== 1'b0) begin errors++; $display("FAIL bp_no_ret[%0d]: got %b expected 0", i, bus.oitf_ret_ena); end
    end
    tick(); bus.wbck_o_ready = 1'b1; settle();
    checks++; if (bus.oitf_ret_ena !== 1'b1) begin errors++; $display("FAIL bp_release_ret: got %b expected 1", bus.oitf_ret_ena); end
    tick(); bus.oitf_ret_ptr = 2'd2; settle();
    checks++; if (bus.wbck_o_valid !== 1'b1 || bus.wbck_o_wdat !== 32'hB1B1B1B1 || bus.wbck_o_rdidx !== 5'd2) begin errors++; $display("FAIL bp_second: got %b/%h/%0d expected 1/b1b1b1b1/2", bus.wbck_o_valid, bus.wbck_o_wdat, bus.wbck_o_rdidx); end
    tick(); settle();
    checks++; if (bus.wbck_o_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", bus.wbck_o_valid); end
    $display("test_backpressure done");
  endtask

  task automatic test_rdwen0();
    bus.oitf_ret_ptr = 2'd3; bus.wbck_o_ready = 1'b0;
    set_ch(0, 1'b1, 32'hC0C0C0C0, 5'd7, 1'b1, 2'd3);
    tick(); idle(); settle();
    checks++; if (bus.oitf_ret_ena !== 1'b1) begin errors++; $display("FAIL rdwen0_load: got %b expected 1", bus.oitf_ret_ena); end
    tick(); bus.oitf_ret_ptr = 2'd0;
    set_ch(1, 1'b1, 32'hC1C1C1C1, 5'd9, 1'b0, 2'd0);
    tick(); idle(); settle();
    checks++; if (bus.oitf_ret_ena !== 1'b1) begin errors++; $display("FAIL rdwen0_ret: got %b expected 1", bus.oitf_ret_ena); end
    tick(); bus.oitf_ret_ptr = 2'd1; settle();
    checks++; if (bus.wbck_o_valid !== 1'b1 || bus.wbck_o_wdat !== 32'hC0C0C0C0 || bus.wbck_o_rdidx !== 5'd7) begin errors++; $display("FAIL rdwen0_out_kept: got %b/%h/%0d expected 1/c0c0c0c0/7", bus.wbck_o_valid, bus.wbck_o_wdat, bus.wbck_o_rdidx); end
    checks++; if (bus.oitf_ret_ena !== 1'b0) begin errors++; $display("FAIL rdwen0_single_pulse: got %b expected 0", bus.oitf_ret_ena); end
    bus.wbck_o_ready = 1'b1;
    tick(); settle();
    checks++; if (bus.wbck_o_valid !== 1'b0) begin errors++; $display("FAIL rdwen0_drain: got %b expected 0", bus.wbck_o_valid); end
    $display("test_rdwen0 done");
  endtask

  task automatic test_fifo_wrap();
    logic [XL-1:0] d0, d1;
    bus.wbck_o_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      bus.oitf_ret_ptr = 2'd2;
      d0 = 32'h1000_0000 + 32'(r * 16);
      d1 = d0 + 32'd1;
      set_ch(0, 1'b1, d0, 5'(r), 1'b1, 2'd0);
      settle();
      checks++; if (bus.ch_i_ready[0] !== 1'b1) begin errors++; $display("FAIL wrap_ready_empty[%0d]: got %b expected 1", r, bus.ch_i_ready[0]); end
      tick();
      set_ch(0, 1'b1, d1, 5'(r + 16), 1'b1, 2'd0);
      settle();
      checks++; if (bus.ch_i_ready[0] !== 1'b1) begin errors++; $display("FAIL wrap_ready_one[%0d]: got %b expected 1", r, bus.ch_i_ready[0]); end
      tick(); idle(); settle();
      checks++; if (bus.ch_i_ready[0] !== 1'b0 || bus.oitf_ret_ena !== 1'b0) begin errors++; $display("FAIL wrap_full[%0d]: got ready=%b ret=%b expected 0/0", r, bus.ch_i_ready[0], bus.oitf_ret_ena); end
      bus.oitf_ret_ptr = 2'd0;
      #1;
      checks++; if (bus.oitf_ret_ena !== 1'b1) begin errors++; $display("FAIL wrap_ret0[%0d]: got %b expected 1", r, bus.oitf_ret_ena); end
      tick(); settle();
      checks++; if (bus.oitf_ret_ena !== 1'b1 || bus.ch_i_ready[0] !== 1'b1) begin errors++; $display("FAIL wrap_ret1[%0d]: got ret=%b ready=%b expected 1/1", r, bus.oitf_ret_ena, bus.ch_i_ready[0]); end
      checks++; if (bus.wbck_o_wdat !== d0) begin errors++; $display("FAIL wrap_order0[%0d]: got %h expected %h", r, bus.wbck_o_wdat, d0); end
      tick(); bus.oitf_ret_ptr = 2'd2; settle();
      checks++; if (bus.wbck_o_wdat !== d1 || bus.wbck_o_rdidx !== 5'(r + 16)) begin errors++; $display("FAIL wrap_order1[%0d]: got %h/%0d expected %h/%0d", r, bus.wbck_o_wdat, bus.wbck_o_rdidx, d1, r + 16); end
      tick();
    end
    $display("test_fifo_wrap done");
  endtask

  task automatic test_dup_reset();
    bus.oitf_ret_ptr = 2'd3; bus.wbck_o_ready = 1'b1;
    set_ch(0, 1'b1, 32'hE0E0E0E0, 5'd3, 1'b1, 2'd2);
    set_ch(1, 1'b1, 32'hE1E1E1E1, 5'd4, 1'b1, 2'd2);
    tick(); idle(); bus.oitf_ret_ptr = 2'd2; settle();
    checks++; if (bus.oitf_ret_ena !== 1'b1 || bus.err_dup_match !== 1'b0) begin errors++; $display("FAIL dup_pop: got ret=%b err=%b expected 1/0", bus.oitf_ret_ena, bus.err_dup_match); end
    tick(); bus.oitf_ret_ptr = 2'd3; settle();
    checks++; if (bus.err_dup_match !== 1'b1) begin errors++; $display("FAIL dup_err_set: got %b expected 1", bus.err_dup_match); end
    checks++; if (bus.wbck_o_wdat !== 32'hE0E0E0E0 || bus.wbck_o_rdidx !== 5'd3) begin errors++; $display("FAIL dup_winner: got %h/%0d expected e0e0e0e0/3", bus.wbck_o_wdat, bus.wbck_o_rdidx); end
    tick(); settle();
    checks++; if (bus.err_dup_match !== 1'b1) begin errors++; $display("FAIL dup_err_sticky: got %b expected 1", bus.err_dup_match); end
    rst = 1'b1; bus.oitf_ret_ptr = 2'd2;
    #1;
    checks++; if (bus.ch_i_ready !== 2'b00 || bus.oitf_ret_ena !== 1'b0) begin errors++; $display("FAIL dup_rst_comb: got ready=%b ret=%b expected 00/0", bus.ch_i_ready, bus.oitf_ret_ena); end
    tick(); rst = 1'b0; settle();
    checks++; if (bus.wbck_o_valid !== 1'b0 || bus.wbck_o_wdat !== 32'h0 || bus.wbck_o_rdidx !== 5'd0 || bus.err_dup_match !== 1'b0) begin errors++; $display("FAIL dup_rst_outputs: got %b/%h/%0d/%b expected 0/0/0/0", bus.wbck_o_valid, bus.wbck_o_wdat, bus.wbck_o_rdidx, bus.err_dup_match); end
    checks++; if (bus.oitf_ret_ena !== 1'b0 || bus.ch_i_ready !== 2'b11) begin errors++; $display("FAIL dup_rst_flushed: got ret=%b ready=%b expected 0/11", bus.oitf_ret_ena, bus.ch_i_ready); end
    tick();
    $display("test_dup_reset done");
  endtask

  // Instructions n = 0..N-1 get itag n mod 4 and a random channel; each channel
  // emits its own instructions in order, at most four instructions in flight.
  task automatic test_random();
    logic [XL-1:0] i_d [N];
    logic [RW-1:0] i_r [N];
    logic          i_we [N];
    int            chlist [CH][$];
    int            fifo_q [CH][$];
    int            wb_q [$];
    logic [CH-1:0] pv;
    logic [CH-1:0] can_push;
    int retired, cyc, pk, n, exp_w;
    logic mvalid, rdy, exp_pop, slot_free;

    for (int i = 0; i < N; i++) begin
      i_d[i]  = $urandom;
      i_r[i]  = 5'($urandom_range(31));
      i_we[i] = ($urandom_range(3) != 0);
      chlist[$urandom_range(CH - 1)].push_back(i);
      if (i_we[i]) wb_q.push_back(i);
    end
    retired = 0; cyc = 0; mvalid = 1'b0;
    while ((retired < N || mvalid) && cyc < 3000) begin
      for (int k = 0; k < CH; k++) begin
        pv[k] = 1'b0;
        if (chlist[k].size() > 0 && chlist[k][0] < retired + 4 && $urandom_range(3) != 0) begin
          n = chlist[k][0];
          pv[k] = 1'b1;
          set_ch(k, 1'b1, i_d[n], i_r[n], i_we[n], 2'(n));
        end else begin
          bus.ch_i_valid[k] = 1'b0;
        end
      end
      rdy = ($urandom_range(3) != 0);
      bus.wbck_o_ready = rdy;
      bus.oitf_ret_ptr = 2'(retired);
      bus.oitf_empty = (retired >= N);
      settle();

      for (int k = 0; k < CH; k++) begin
        can_push[k] = pv[k] && (fifo_q[k].size() < DEPTH);
        checks++; if (bus.ch_i_ready[k] !== (fifo_q[k].size() < DEPTH)) begin errors++; $display("FAIL rnd_ready[%0d] cyc %0d: got %b expected %b", k, cyc, bus.ch_i_ready[k], fifo_q[k].size() < DEPTH); end
      end
      pk = -1;
      for (int k = 0; k < CH; k++)
        if (retired < N && fifo_q[k].size() > 0 && (fifo_q[k][0] % 4) == (retired % 4)) pk = k;
      slot_free = !mvalid || rdy;
      exp_pop = (pk >= 0) && (!i_we[fifo_q[pk][0]] || slot_free);
      checks++; if (bus.oitf_ret_ena !== exp_pop) begin errors++; $display("FAIL rnd_ret_ena cyc %0d: got %b expected %b", cyc, bus.oitf_ret_ena, exp_pop); end
      checks++; if (bus.wbck_o_valid !== mvalid) begin errors++; $display("FAIL rnd_valid cyc %0d: got %b expected %b", cyc, bus.wbck_o_valid, mvalid); end
      if (mvalid && rdy) begin
        exp_w = (wb_q.size() > 0) ? wb_q.pop_front() : 0;
        $display("wb transfer itag=%0d data=%h rd=%0d", exp_w % 4, bus.wbck_o_wdat, bus.wbck_o_rdidx);
        checks++; if (bus.wbck_o_wdat !== i_d[exp_w] || bus.wbck_o_rdidx !== i_r[exp_w]) begin errors++; $display("FAIL rnd_wb_order instr %0d: got %h/%0d expected %h/%0d", exp_w, bus.wbck_o_wdat, bus.wbck_o_rdidx, i_d[exp_w], i_r[exp_w]); end
      end

      mvalid = (exp_pop && i_we[fifo_q[pk][0]]) || (mvalid && !rdy);
      if (exp_pop) begin
        void'(fifo_q[pk].pop_front());
        retired++;
      end
      for (int k = 0; k < CH; k++)
        if (can_push[k]) fifo_q[k].push_back(chlist[k].pop_front());
      cyc++;
      tick();
    end
    idle();
    checks++; if (retired != N || wb_q.size() != 0) begin errors++; $display("FAIL rnd_complete: got retired=%0d pending_wb=%0d expected %0d/0", retired, wb_q.size(), N); end
    $display("test_random done after %0d cycles", cyc);
  endtask

  initial begin
    test_reset();
    test_single();
    test_out_of_order();
    test_backpressure();
    test_rdwen0();
    test_fifo_wrap();
    test_dup_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/e203_exu_wbck_rob.md
# e203_exu_wbck_rob

Parametrised multi-channel long-pipe write-back unit for the E203 EXU. It accepts results from `CH_NUM` out-of-order execution channels (ALU, MULDIV, LSU, …) into per-channel FIFOs. It releases them strictly in OITF order by matching each FIFO head's itag against the OITF head pointer. It drives a single registered write-back port to the regfile arbiter and pulses the OITF retire strobe. It sits between the execution units and the final write-back arbiter, replacing the single-channel, combinational itag-match write-back path.

## Interface
- `CH_NUM`, 2: number of producer channels (1–8)
- `FIFO_DEPTH`, 2: entries per channel FIFO (power of two, ≥2)
- `XLEN`, 32: write-back data width
- `RFIDX_W`, 5: register index width
- `ITAG_W`, 2: itag width (log2 of OITF depth)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous reset, active-high
- `ch_i_valid`  in  CH_NUM  per-channel result valid
- `ch_i_ready`  out  CH_NUM  per-channel accept (FIFO not full)
- `ch_i_wdat`  in  CH_NUM*XLEN  result data, channel k at [k*XLEN +: XLEN]
- `ch_i_rdidx`  in  CH_NUM*RFIDX_W  destination register
- `ch_i_rdwen`  in  CH_NUM  1 = result writes regfile
- `ch_i_itag`  in  CH_NUM*ITAG_W  OITF itag of the instruction
- `oitf_empty`  in  1  OITF has no entries
- `oitf_ret_ptr`  in  ITAG_W  itag of OITF head
- `oitf_ret_ena`  out  1  retire pulse, OITF head popped this cycle
- `wbck_o_valid`  out  1  registered write-back valid
- `wbck_o_ready`  in  1  regfile arbiter accepts
- `wbck_o_wdat`  out  XLEN  write-back data
- `wbck_o_rdidx`  out  RFIDX_W  write-back register
- `err_dup_match`  out  1  sticky: more than one FIFO head matched `oitf_ret_ptr` in one cycle

## Operation
- Push: channel k enqueues when `ch_i_valid[k] & ch_i_ready[k]`. `ch_i_ready[k] = ~full[k]`; it does not depend on a same-cycle pop.
- Head match: `match[k] = head_vld[k] & (head_itag[k] == oitf_ret_ptr) & ~oitf_empty`.
- Selection: lowest-index k with `match[k]`. Itags are unique, so more than one match is illegal. If it happens, the lowest index still wins and `err_dup_match` is set and held until `rst`.
- Slot free: `slot_free = ~wbck_o_valid | wbck_o_ready`.
- Retire: a matched head with `rdwen=1` pops only when `slot_free`, loading `{wdat, rdidx}` into the output register. A matched head with `rdwen=0` pops unconditionally and does not touch the output register.
- `oitf_ret_ena = ` (a pop happened this cycle). It is combinational from the FIFO heads, `oitf_*`, and `wbck_o_ready`. At most one pop per cycle.
- Output register:
  - Set on load.
  - Cleared on `wbck_o_valid & wbck_o_ready` with no load.
  - Load and drain in the same cycle keeps valid=1 with the new data.
- Data and rdidx hold their values while `wbck_o_valid & ~wbck_o_ready`.
- FIFO: circular buffer with read/write pointers of width log2(FIFO_DEPTH)+1. Pointers wrap; full when the MSBs differ and the LSBs are equal. Simultaneous push and pop on a full FIFO is not allowed because ready=0. On a non-full, non-empty FIFO, simultaneous push and pop keeps the count unchanged.
- A push into an empty FIFO is not bypassed; it is visible at the head the next cycle.

## Timing
- Reset (`rst` high at a clock edge): all FIFOs empty, `wbck_o_valid=0`, `wbck_o_wdat=0`, `wbck_o_rdidx=0`, `err_dup_match=0`.
- While `rst` is high, `ch_i_ready`=0 and `oitf_ret_ena`=0 combinationally. Asserting `rst` mid-transfer discards all buffered results.
- Latency for an input accepted at cycle t into an empty FIFO, when its itag is at the OITF head:
  - `oitf_ret_ena` pulses at t+1.
  - `wbck_o_valid` is 1 at t+2.
- Throughput: one retire per cycle while the matching heads exist and `wbck_o_ready=1`.
- `wbck_o_ready` low stalls only `rdwen=1` retires.
- `oitf_empty=1` blocks all pops regardless of head contents.

## Test plan
- **Single result:** CH_NUM=2. Ch0 pushes itag=0, wdat=0xDEADBEEF, rdidx=5, rdwen=1 at t0, with `oitf_ret_ptr=0` and ready=1. Required: `oitf_ret_ena`=1 at t0+1 and `wbck_o_valid`=1 at t0+2 carrying 0xDEADBEEF/5.
- **Out-of-order completion:** ch1 pushes itag=1 at t0, and ch0 pushes itag=0 at t0+2. The bench advances `oitf_ret_ptr` 0→1 after each `oitf_ret_ena`. Required: ch1 is held until ch0 retires, the write-back order is itag0 then itag1, and there are two `oitf_ret_ena` pulses in consecutive cycles.
- **Backpressure:** hold `wbck_o_ready=0` for 4 cycles with two matching results queued. Required: `wbck_o_wdat` is stable and no second `oitf_ret_ena` occurs. After ready rises, the second result follows one cycle later.
- **rdwen=0 retire:** push itag=0 with rdwen=0 while the output is stalled holding another result. Required: `oitf_ret_ena` pulses and the output register is unchanged.
- **FIFO full and wrap:** FIFO_DEPTH=2. Push 2 entries to ch0 with a non-matching head, then retire them and push again 3 times. Required: `ch_i_ready[0]`=0 exactly when 2 entries are held, and the data order is preserved across pointer wrap.
- **Duplicate match and reset:** force both heads to carry itag=2 with `oitf_ret_ptr=2`. Required: ch0 is popped and `err_dup_match`=1 and stays set. Assert `rst` for 1 cycle. Required: all outputs are 0 and the FIFOs are empty.
